// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared register-file constants and writeback enums
//
// Purpose: common definitions for the register file writeback path.
// Ports:   none (package).
package gpu_pkg;

   localparam int RF_AW    = 4;
   localparam int RF_DW    = 64;
   localparam int RF_DEPTH = 16;

   // r15 reads as zero, so writes to it are dropped at the port.
   localparam logic [RF_AW-1:0] REG_ZERO = 4'hF;
   // r14 holds the thread id and is normally preloaded by the host.
   localparam logic [RF_AW-1:0] REG_TID  = 4'hE;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_LSU,
      SRC_HOST
   } wb_src_e;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } starve_st_e;

   function automatic logic rf_writable(input logic [RF_AW-1:0] rd);
      return rd != REG_ZERO;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-load scoreboard with 3-way hazard lookup
//
// Purpose: tracks registers that are destinations of outstanding loads.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   set, set_rd       load dispatched to set_rd (r15 ignored)
//   clr, clr_rd       load data for clr_rd accepted by the write port
//   q_rs1/q_rs2/q_rd  registers of the instruction in issue
//   hazard            any queried register has a load pending
//   err               sticky: set hit a register already pending
module wb_scoreboard
   import gpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set,
   input  logic [RF_AW-1:0] set_rd,
   input  logic             clr,
   input  logic [RF_AW-1:0] clr_rd,
   input  logic [RF_AW-1:0] q_rs1,
   input  logic [RF_AW-1:0] q_rs2,
   input  logic [RF_AW-1:0] q_rd,
   output logic             hazard,
   output logic             err
);

   logic [RF_DEPTH-1:0] pending;
   logic [RF_DEPTH-1:0] set_mask;
   logic [RF_DEPTH-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set && rf_writable(set_rd)) set_mask[set_rd] = 1'b1;
      if (clr)                        clr_mask[clr_rd] = 1'b1;
   end

   // Set is applied after clear so a same-cycle set/clear leaves the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         err     <= 1'b0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
         err     <= err | (|(set_mask & pending));
      end
   end

   // Looks at registered state only: a clear in this cycle is not bypassed.
   assign hazard = pending[q_rs1] | pending[q_rs2] | pending[q_rd];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter (ALU > LSU > host)
//
// Purpose: shares the single register file write port between ALU writeback,
// LSU load return and the host loader, keeps the load scoreboard and raises
// alu_hold when load returns have been blocked too long.
// Ports:
//   clk, rst_n                                 clock, async active-low reset
//   alu_wb_valid/rd/data                       ALU result, always accepted
//   lsu_wb_valid/ready/rd/data                 load return handshake
//   host_valid/ready/rd/data, core_halted      host loader, only when halted
//   sb_set, sb_set_rd                          load dispatched by issue
//   q_rs1, q_rs2, q_rd, hazard                 issue-stage hazard query
//   alu_hold                                   ask issue to stop ALU ops
//   sb_err                                     sticky double-set error
//   rf_we, rf_rd_addr, rf_rd_data              registered write port
module regfile_wb_arbiter
   import gpu_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_wb_valid,
   input  logic [RF_AW-1:0] alu_wb_rd,
   input  logic [RF_DW-1:0] alu_wb_data,
   input  logic             lsu_wb_valid,
   output logic             lsu_wb_ready,
   input  logic [RF_AW-1:0] lsu_wb_rd,
   input  logic [RF_DW-1:0] lsu_wb_data,
   input  logic             host_valid,
   output logic             host_ready,
   input  logic [RF_AW-1:0] host_rd,
   input  logic [RF_DW-1:0] host_data,
   input  logic             core_halted,
   input  logic             sb_set,
   input  logic [RF_AW-1:0] sb_set_rd,
   input  logic [RF_AW-1:0] q_rs1,
   input  logic [RF_AW-1:0] q_rs2,
   input  logic [RF_AW-1:0] q_rd,
   output logic             hazard,
   output logic             alu_hold,
   output logic             sb_err,
   output logic             rf_we,
   output logic [RF_AW-1:0] rf_rd_addr,
   output logic [RF_DW-1:0] rf_rd_data
);

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   wb_src_e          src;
   logic [RF_AW-1:0] win_rd;
   logic [RF_DW-1:0] win_data;
   logic             lsu_accept;
   logic             lsu_blocked;
   logic [CNT_W-1:0] wait_cnt;
   starve_st_e       state;
   starve_st_e       next_state;

   // Fixed priority. The ALU cannot stall, so it wins even while alu_hold is up;
   // the hold only stops new ALU ops from being issued.
   always_comb begin
      src = SRC_NONE;
      if (alu_wb_valid)                   src = SRC_ALU;
      else if (lsu_wb_valid)              src = SRC_LSU;
      else if (host_valid && core_halted) src = SRC_HOST;
   end

   always_comb begin
      win_rd   = '0;
      win_data = '0;
      unique case (src)
         SRC_ALU:  begin win_rd = alu_wb_rd;  win_data = alu_wb_data;  end
         SRC_LSU:  begin win_rd = lsu_wb_rd;  win_data = lsu_wb_data;  end
         SRC_HOST: begin win_rd = host_rd;    win_data = host_data;    end
         default:  begin win_rd = '0;         win_data = '0;           end
      endcase
   end

   assign lsu_wb_ready = (src == SRC_LSU);
   assign host_ready   = (src == SRC_HOST);
   assign lsu_accept   = lsu_wb_valid & lsu_wb_ready;
   assign lsu_blocked  = lsu_wb_valid & ~lsu_wb_ready;

   // r15 writes complete their handshake and update addr/data, but never
   // assert rf_we.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we      <= 1'b0;
         rf_rd_addr <= '0;
         rf_rd_data <= '0;
      end else if (src != SRC_NONE) begin
         rf_we      <= rf_writable(win_rd);
         rf_rd_addr <= win_rd;
         rf_rd_data <= win_data;
      end else begin
         rf_we      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!lsu_wb_valid || lsu_accept) begin
         wait_cnt <= '0;
      end else if (wait_cnt != CNT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: if (lsu_blocked && wait_cnt == LIMIT_M1) next_state = ST_HOLD;
         ST_HOLD: if (lsu_accept || !lsu_wb_valid)         next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   assign alu_hold = (state == ST_HOLD);

   wb_scoreboard u_scoreboard (
      .clk    (clk),
      .rst_n  (rst_n),
      .set    (sb_set),
      .set_rd (sb_set_rd),
      .clr    (lsu_accept),
      .clr_rd (lsu_wb_rd),
      .q_rs1  (q_rs1),
      .q_rs2  (q_rs2),
      .q_rd   (q_rd),
      .hazard (hazard),
      .err    (sb_err)
   );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_wb_valid;
   logic [3:0]  alu_wb_rd;
   logic [63:0] alu_wb_data;
   logic        lsu_wb_valid;
   logic        lsu_wb_ready;
   logic [3:0]  lsu_wb_rd;
   logic [63:0] lsu_wb_data;
   logic        host_valid;
   logic        host_ready;
   logic [3:0]  host_rd;
   logic [63:0] host_data;
   logic        core_halted;
   logic        sb_set;
   logic [3:0]  sb_set_rd;
   logic [3:0]  q_rs1, q_rs2, q_rd;
   logic        hazard, alu_hold, sb_err, rf_we;
   logic [3:0]  rf_rd_addr;
   logic [63:0] rf_rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
      .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
      .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
      .host_valid(host_valid), .host_ready(host_ready),
      .host_rd(host_rd), .host_data(host_data), .core_halted(core_halted),
      .sb_set(sb_set), .sb_set_rd(sb_set_rd),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
      .hazard(hazard), .alu_hold(alu_hold), .sb_err(sb_err),
      .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
   );

   typedef struct packed {
      logic        alu_v;  logic [3:0] alu_rd;  logic [63:0] alu_d;
      logic        lsu_v;  logic [3:0] lsu_rd;  logic [63:0] lsu_d;
      logic        host_v; logic [3:0] host_rd; logic [63:0] host_d;
      logic        halted; logic set; logic [3:0] set_rd;
      logic [3:0]  q1; logic [3:0] q2; logic [3:0] qd;
      logic        e_lrdy; logic e_hrdy; logic e_haz;
      logic        e_we; logic [3:0] e_addr; logic [63:0] e_data; logic e_err;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic av, input logic [3:0] ar, input logic [63:0] ad,
      input logic lv, input logic [3:0] lr, input logic [63:0] ld,
      input logic hv, input logic [3:0] hr, input logic [63:0] hd,
      input logic hl, input logic st, input logic [3:0] sr,
      input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
      input logic elr, input logic ehr, input logic ehz,
      input logic ewe, input logic [3:0] ea, input logic [63:0] ed, input logic eer);
      vec_t v;
      v = '{alu_v:av, alu_rd:ar, alu_d:ad, lsu_v:lv, lsu_rd:lr, lsu_d:ld,
            host_v:hv, host_rd:hr, host_d:hd, halted:hl, set:st, set_rd:sr,
            q1:a, q2:b, qd:c, e_lrdy:elr, e_hrdy:ehr, e_haz:ehz,
            e_we:ewe, e_addr:ea, e_data:ed, e_err:eer};
      return v;
   endfunction

   task automatic chk(input string what, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h, expected %h", what, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
      lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
      host_valid = 0; host_rd = 0; host_data = 0; core_halted = 0;
      sb_set = 0; sb_set_rd = 0; q_rs1 = 0; q_rs2 = 0; q_rd = 0;
   endtask

   task automatic apply(input vec_t v);
      alu_wb_valid = v.alu_v;  alu_wb_rd = v.alu_rd;  alu_wb_data = v.alu_d;
      lsu_wb_valid = v.lsu_v;  lsu_wb_rd = v.lsu_rd;  lsu_wb_data = v.lsu_d;
      host_valid = v.host_v;   host_rd = v.host_rd;   host_data = v.host_d;
      core_halted = v.halted;  sb_set = v.set;        sb_set_rd = v.set_rd;
      q_rs1 = v.q1; q_rs2 = v.q2; q_rd = v.qd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //         alu           lsu              host                         hl st sr  q1 q2 qd  lr hr hz  we addr data                    err
      vecs[0]  = mk(1,3,64'h1111, 1,5,64'h5555, 0,0,0,                     0, 0,0, 0,0,0,  0,0,0,  1,3,64'h1111,               0);
      vecs[1]  = mk(0,0,0,        1,5,64'h5555, 0,0,0,                     0, 0,0, 0,0,0,  1,0,0,  1,5,64'h5555,               0);
      vecs[2]  = mk(0,0,0,        0,0,0,        0,0,0,                     0, 0,0, 0,0,0,  0,0,0,  0,5,64'h5555,               0);
      vecs[3]  = mk(1,15,64'hAAAA,0,0,0,        0,0,0,                     0, 0,0, 0,0,0,  0,0,0,  0,15,64'hAAAA,              0);
      vecs[4]  = mk(0,0,0,        1,15,64'hBBBB,0,0,0,                     0, 0,0, 0,0,0,  1,0,0,  0,15,64'hBBBB,              0);
      vecs[5]  = mk(0,0,0,        0,0,0,        0,0,0,                     0, 1,7, 0,7,0,  0,0,0,  0,15,64'hBBBB,              0);
      vecs[6]  = mk(0,0,0,        0,0,0,        0,0,0,                     0, 0,0, 0,7,0,  0,0,1,  0,15,64'hBBBB,              0);
      vecs[7]  = mk(0,0,0,        1,7,64'h7777, 0,0,0,                     0, 0,0, 0,7,0,  1,0,1,  1,7,64'h7777,               0);
      vecs[8]  = mk(0,0,0,        0,0,0,        0,0,0,                     0, 0,0, 0,7,0,  0,0,0,  0,7,64'h7777,               0);
      vecs[9]  = mk(0,0,0,        1,7,64'h7070, 0,0,0,                     0, 1,7, 7,0,0,  1,0,0,  1,7,64'h7070,               0);
      vecs[10] = mk(0,0,0,        0,0,0,        0,0,0,                     0, 0,0, 0,0,7,  0,0,1,  0,7,64'h7070,               0);
      vecs[11] = mk(0,0,0,        0,0,0,        0,0,0,                     0, 1,7, 7,0,0,  0,0,1,  0,7,64'h7070,               1);
      vecs[12] = mk(0,0,0,        0,0,0,        0,0,0,                     0, 0,0, 0,0,0,  0,0,0,  0,7,64'h7070,               1);
      vecs[13] = mk(1,7,64'hABCD, 0,0,0,        0,0,0,                     0, 0,0, 7,0,0,  0,0,1,  1,7,64'hABCD,               1);
      vecs[14] = mk(0,0,0,        0,0,0,        0,0,0,                     0, 0,0, 7,0,0,  0,0,1,  0,7,64'hABCD,               1);
      vecs[15] = mk(0,0,0,        0,0,0,        1,14,64'h0003000200010000, 0, 0,0, 0,0,0,  0,0,0,  0,7,64'hABCD,               1);
      vecs[16] = mk(0,0,0,        1,2,64'h2222, 1,14,64'h0003000200010000, 1, 0,0, 0,0,0,  1,0,0,  1,2,64'h2222,               1);
      vecs[17] = mk(0,0,0,        0,0,0,        1,14,64'h0003000200010000, 1, 0,0, 7,0,0,  0,1,1,  1,14,64'h0003000200010000, 1);
      vecs[18] = mk(0,0,0,        0,0,0,        1,7,64'h77,                1, 0,0, 7,0,0,  0,1,1,  1,7,64'h77,                 1);
      vecs[19] = mk(0,0,0,        0,0,0,        0,0,0,                     0, 0,0, 7,0,0,  0,0,1,  0,7,64'h77,                 1);
      vecs[20] = mk(1,1,64'h0101, 0,0,0,        1,14,64'h9,                1, 0,0, 0,0,0,  0,0,0,  1,1,64'h0101,               1);

      // Reset asserted with every input active.
      idle_inputs();
      alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 64'h1234;
      lsu_wb_valid = 1; lsu_wb_rd = 5; host_valid = 1; core_halted = 1;
      sb_set = 1; sb_set_rd = 7; q_rs1 = 7; q_rs2 = 7; q_rd = 7;
      rst_n = 0;
      #1;
      chk("reset_rf_we_async", 0, rf_we, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("reset_rf_we", i, rf_we, 0);
         chk("reset_addr", i, rf_rd_addr, 0);
         chk("reset_data", i, rf_rd_data, 0);
         chk("reset_hazard", i, hazard, 0);
         chk("reset_alu_hold", i, alu_hold, 0);
         chk("reset_sb_err", i, sb_err, 0);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1;

      // Table-driven vectors: comb outputs before the edge, port after it.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         chk("lsu_wb_ready", i, lsu_wb_ready, vecs[i].e_lrdy);
         chk("host_ready", i, host_ready, vecs[i].e_hrdy);
         chk("hazard", i, hazard, vecs[i].e_haz);
         @(posedge clk); #1;
         chk("rf_we", i, rf_we, vecs[i].e_we);
         chk("rf_rd_addr", i, rf_rd_addr, vecs[i].e_addr);
         chk("rf_rd_data", i, rf_rd_data, vecs[i].e_data);
         chk("sb_err", i, sb_err, vecs[i].e_err);
      end

      // Reset mid-operation: in-flight write and pending r7 are dropped.
      @(negedge clk);
      idle_inputs();
      q_rs1 = 7;
      #1;
      chk("midreset_pre_we", 0, rf_we, 1);
      chk("midreset_pre_hazard", 0, hazard, 1);
      rst_n = 0;
      #1;
      chk("midreset_rf_we", 0, rf_we, 0);
      chk("midreset_addr", 0, rf_rd_addr, 0);
      chk("midreset_hazard", 0, hazard, 0);
      chk("midreset_sb_err", 0, sb_err, 0);
      @(negedge clk);
      rst_n = 1;

      // Host stalls while the core runs, then writes r14 once halted.
      @(negedge clk);
      host_valid = 1; host_rd = 4'hE; host_data = 64'h0003000200010000; q_rs1 = 4'hE;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("host_stall_ready", i, host_ready, 0);
         @(posedge clk); #1;
         chk("host_stall_we", i, rf_we, 0);
         @(negedge clk);
      end
      core_halted = 1;
      #1;
      chk("host_go_ready", 0, host_ready, 1);
      @(posedge clk); #1;
      chk("host_go_we", 0, rf_we, 1);
      chk("host_go_addr", 0, rf_rd_addr, 4'hE);
      chk("host_go_data", 0, rf_rd_data, 64'h0003000200010000);
      chk("host_go_hazard", 0, hazard, 0);
      @(negedge clk);
      idle_inputs();

      // Starvation: 5 blocked cycles, LSU drops (counter clears), then 8 more.
      alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 64'h4444;
      lsu_wb_valid = 1; lsu_wb_rd = 3; lsu_wb_data = 64'h3333;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("starve_a_ready", i, lsu_wb_ready, 0);
         @(posedge clk); #1;
         chk("starve_a_hold", i, alu_hold, 0);
         @(negedge clk);
      end
      lsu_wb_valid = 0;
      @(posedge clk); #1;
      chk("starve_gap_hold", 0, alu_hold, 0);
      @(negedge clk);
      lsu_wb_valid = 1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("starve_b_hold", i, alu_hold, (i == 7) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      // ALU results are still written while in HOLD.
      @(posedge clk); #1;
      chk("hold_alu_we", 0, rf_we, 1);
      chk("hold_alu_addr", 0, rf_rd_addr, 1);
      chk("hold_alu_hold", 0, alu_hold, 1);
      @(negedge clk);
      lsu_wb_valid = 0;
      @(posedge clk); #1;
      chk("hold_exit_drop", 0, alu_hold, 0);
      @(negedge clk);
      lsu_wb_valid = 1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk("starve_c_hold", 0, alu_hold, 1);
      alu_wb_valid = 0;
      #1;
      chk("hold_lsu_ready", 0, lsu_wb_ready, 1);
      chk("hold_still_up", 0, alu_hold, 1);
      @(posedge clk); #1;
      chk("hold_exit_accept", 0, alu_hold, 0);
      chk("hold_lsu_we", 0, rf_we, 1);
      chk("hold_lsu_addr", 0, rf_rd_addr, 3);
      chk("hold_lsu_data", 0, rf_rd_data, 64'h3333);
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
